// File: rtl/muldiv_pkg.sv
// Shared types for the RV32M multiply/divide unit: operation encodings,
// FSM states and the iteration count for the radix-2 datapath.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } muldiv_state_t;

    localparam logic [4:0] ITER_LAST = 5'd31;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: fixed 35-cycle latency from Start to Done,
// one radix-2 step per cycle on operand magnitudes with a final sign fix.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Start,
    input  logic [2:0]            Funct3,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    output logic                  Busy,
    output logic                  Done,
    output logic [DATA_WIDTH-1:0] Result
);

    localparam int W = DATA_WIDTH;

    function automatic logic [W-1:0] magnitude(input logic [W-1:0] v, input logic is_signed);
        return (is_signed && v[W-1]) ? -v : v;
    endfunction

    function automatic logic [W-1:0] fix_sign_w(input logic [W-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*W-1:0] fix_sign_dw(input logic [2*W-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    muldiv_state_t  state_q, state_d;
    muldiv_op_t     op_q, op_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [4:0]     cnt_q, cnt_d;
    logic           neg_q, neg_d;
    logic           dz_q, dz_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [W-1:0]   result_q, result_d;

    logic           op_signed_a, op_signed_b;
    logic [W:0]     mul_sum;
    logic [W:0]     div_trial;
    logic [2*W-1:0] mul_next, div_next;
    logic [2*W-1:0] prod_fixed;
    logic [W-1:0]   quot_fixed, rem_fixed;
    logic [W-1:0]   fix_value;

    assign op_signed_a = op_q inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    assign op_signed_b = op_q inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};

    // acc holds {high product | partial remainder, multiplier | dividend-quotient}
    assign mul_sum   = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? b_q : {W{1'b0}})};
    assign mul_next  = {mul_sum, acc_q[W-1:1]};
    assign div_trial = {acc_q[2*W-1:W], acc_q[W-1]} - {1'b0, b_q};
    assign div_next  = div_trial[W] ? {acc_q[2*W-2:0], 1'b0}
                                    : {div_trial[W-1:0], acc_q[W-2:0], 1'b1};

    assign prod_fixed = fix_sign_dw(acc_q, neg_q);
    assign quot_fixed = fix_sign_w(acc_q[W-1:0], neg_q);
    assign rem_fixed  = fix_sign_w(acc_q[2*W-1:W], neg_q);

    always_comb begin
        fix_value = '0;
        case (op_q)
            OP_MUL:                       fix_value = prod_fixed[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_value = prod_fixed[2*W-1:W];
            OP_DIV, OP_DIVU:              fix_value = dz_q ? {W{1'b1}} : quot_fixed;
            default:                      fix_value = dz_q ? a_q : rem_fixed;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        dz_d     = dz_q;
        result_d = result_q;

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    op_d    = muldiv_op_t'(Funct3);
                    a_d     = SrcA;
                    b_d     = SrcB;
                    state_d = ST_PREP;
                end
            end
            ST_PREP: begin
                // a_q keeps the raw dividend for the divide-by-zero remainder
                b_d     = magnitude(b_q, op_signed_b);
                acc_d   = {{W{1'b0}}, magnitude(a_q, op_signed_a)};
                neg_d   = (op_q == OP_REM) ? a_q[W-1]
                                           : ((op_signed_a & a_q[W-1]) ^ (op_signed_b & b_q[W-1]));
                dz_d    = (b_q == '0);
                cnt_d   = ITER_LAST;
                state_d = ST_CALC;
            end
            ST_CALC: begin
                acc_d = op_q[2] ? div_next : mul_next;
                if (cnt_q == 5'd0) begin
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            ST_FIX: begin
                result_d = fix_value;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = state_d inside {ST_PREP, ST_CALC, ST_FIX};
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MUL;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            dz_q     <= dz_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign Busy   = busy_q;
    assign Done   = done_q;
    assign Result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: an arithmetic reference model checked every cycle,
// plus directed vectors with hand-computed results and latency checks.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk;
    logic        reset;
    logic        Start;
    logic [2:0]  Funct3;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        Busy;
    logic        Done;
    logic [31:0] Result;

    int vectors = 0;
    int miscompares = 0;

    muldiv_unit #(.DATA_WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .Start  (Start),
        .Funct3 (Funct3),
        .SrcA   (SrcA),
        .SrcB   (SrcB),
        .Busy   (Busy),
        .Done   (Done),
        .Result (Result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    // Reference arithmetic straight from the RV32M definitions
    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa;
        longint sb;
        longint ub;
        logic [63:0] p;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        ub = longint'({32'b0, b});
        p  = '0;
        case (op)
            3'b000: begin p = sa * sb; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'b100: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb;
                return p[31:0];
            end
            3'b101: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb;
                return p[31:0];
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    // Timing model: after the accepting edge, Busy for 34 cycles, then Done for one
    bit          m_valid = 1'b0;
    bit          m_active = 1'b0;
    int          m_k = 0;
    logic [31:0] m_result = '0;
    logic [31:0] m_pending = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_valid  = 1'b1;
            m_active = 1'b0;
            m_k      = 0;
            m_result = '0;
        end else if (m_active) begin
            m_k++;
            if (m_k == 34) m_result = m_pending;
            if (m_k == 35) m_active = 1'b0;
        end else if (Start) begin
            m_active  = 1'b1;
            m_k       = 0;
            m_pending = ref_result(Funct3, SrcA, SrcB);
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            compare("busy", {31'b0, Busy}, {31'b0, (m_active && m_k < 34)});
            compare("done", {31'b0, Done}, {31'b0, (m_active && m_k == 34)});
            compare("result", Result, m_result);
        end
    end

    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        Funct3 = op;
        SrcA   = a;
        SrcB   = b;
        Start  = 1'b1;
        @(negedge clk);
        Start  = 1'b0;
        Funct3 = ~op;
        SrcA   = ~a;
        SrcB   = ~b;
    endtask

    // Counts cycles from the accepting edge; Done should first be seen in cycle 35
    task automatic waitDone(input int inject_at, output int lat);
        lat = 1;
        while (Done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
            if (lat == inject_at) begin
                Start  = 1'b1;
                Funct3 = OP_DIVU;
                SrcA   = 32'd100;
                SrcB   = 32'd7;
            end else begin
                Start  = 1'b0;
            end
        end
        if (Done !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL done_timeout: got no Done, want Done within 100 cycles");
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] want, input int lat);
        compare({name, " result"}, Result, want);
        compare({name, " latency"}, lat, 32'd35);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] want;
    } vec_t;

    vec_t vecs [20] = '{
        '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB},
        '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000},
        '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
        '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
        '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD},
        '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF},
        '{3'b101, 32'd100,       32'd7,         32'd14},
        '{3'b111, 32'd100,       32'd7,         32'd2},
        '{3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF},
        '{3'b110, 32'd5,         32'd0,         32'd5},
        '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
        '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000},
        '{3'b100, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_0003},
        '{3'b110, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF},
        '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
        '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
        '{3'b011, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001},
        '{3'b100, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF},
        '{3'b110, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9},
        '{3'b111, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F}
    };

    initial begin
        int lat;
        int done_seen;
        reset  = 1'b1;
        Start  = 1'b0;
        Funct3 = 3'b000;
        SrcA   = '0;
        SrcB   = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        compare("reset busy", {31'b0, Busy}, 32'd0);
        compare("reset done", {31'b0, Done}, 32'd0);
        compare("reset result", Result, 32'd0);

        // Each vector starts in the IDLE cycle right after the previous Done
        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
            waitDone(0, lat);
            checkOutput($sformatf("vec%0d", i), vecs[i].want, lat);
        end

        applyStimulus(OP_MUL, 32'd7, 32'hFFFF_FFFD);
        waitDone(10, lat);
        checkOutput("start_while_busy", 32'hFFFF_FFEB, lat);
        applyStimulus(OP_REMU, 32'd100, 32'd7);
        waitDone(0, lat);
        checkOutput("back_to_back", 32'd2, lat);

        // Reset lands in CALC cycle 15 (cycle 16 after the accepting edge)
        applyStimulus(OP_DIVU, 32'd1000, 32'd3);
        repeat (15) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        compare("mid_reset busy", {31'b0, Busy}, 32'd0);
        compare("mid_reset done", {31'b0, Done}, 32'd0);
        compare("mid_reset result", Result, 32'd0);
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (Done === 1'b1) done_seen++;
        end
        compare("mid_reset no_done", done_seen, 32'd0);
        applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        waitDone(0, lat);
        checkOutput("after_reset", 32'hFFFF_FFFD, lat);

        @(negedge clk);
        reset  = 1'b1;
        Start  = 1'b1;
        Funct3 = OP_MUL;
        SrcA   = 32'd3;
        SrcB   = 32'd4;
        @(negedge clk);
        reset = 1'b0;
        Start = 1'b0;
        compare("reset_over_start busy", {31'b0, Busy}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(3'($urandom_range(0, 7)), $urandom, (i == 3) ? 32'd0 : $urandom);
            waitDone(0, lat);
            compare($sformatf("rand%0d latency", i), lat, 32'd35);
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
